// File: rtl/instruction_encoder_pkg.sv
// Shared instruction definitions for the encoder, its bench and the assembler tooling.
// Holds the encoding-format selector and the major opcodes used by the encoder tests.
package instruction_encoder_pkg;

   // One-hot format select; all-zero selects R-type.
   typedef enum logic [4:0] {
      EncR = 5'b00000,
      EncI = 5'b00001,
      EncS = 5'b00010,
      EncB = 5'b00100,
      EncU = 5'b01000,
      EncJ = 5'b10000
   } EncodingType;

   localparam logic [6:0] OpOpImm  = 7'h13;
   localparam logic [6:0] OpOp     = 7'h33;
   localparam logic [6:0] OpStore  = 7'h23;
   localparam logic [6:0] OpBranch = 7'h63;
   localparam logic [6:0] OpLui    = 7'h37;
   localparam logic [6:0] OpJal    = 7'h6F;

endpackage

// File: rtl/instruction_encoder_if.sv
// Field-set input stream, address load and instruction-memory write stream of the encoder.
// slave  : encoder view (consumes fields, produces out_* / err*)
// master : producer / consumer view (drives fields and out_ready)
interface instruction_encoder_if;
   import instruction_encoder_pkg::*;

   logic        in_valid;
   logic        in_ready;
   EncodingType en;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;
   logic        load_en;
   logic [31:0] load_addr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_addr;
   logic [31:0] out_inst;
   logic        err;
   logic [7:0]  err_count;

   modport slave (
      input  in_valid, en, opcode, funct3, funct7, rd, rs1, rs2, imm, load_en, load_addr,
      input  out_ready,
      output in_ready, out_valid, out_addr, out_inst, err, err_count
   );

   modport master (
      output in_valid, en, opcode, funct3, funct7, rd, rs1, rs2, imm, load_en, load_addr,
      output out_ready,
      input  in_ready, out_valid, out_addr, out_inst, err, err_count
   );

endinterface

// File: rtl/instruction_encoder_imm_range_check.sv
// ImmRangeCheck: reports whether imm is representable in the selected instruction format.
// en  : format select (one-hot, zero = R-type)
// imm : signed immediate
// ok  : 1 when imm fits the format (R-type always ok, malformed selects never ok)
module instruction_encoder_imm_range_check
   import instruction_encoder_pkg::*;
(
   input  EncodingType en,
   input  logic [31:0] imm,
   output logic        ok
);

   always_comb begin
      ok = 1'b0;
      case (en)
         EncR:       ok = 1'b1;
         EncI, EncS: ok = (imm == {{20{imm[11]}}, imm[11:0]});
         EncB:       ok = (imm == {{19{imm[12]}}, imm[12:0]}) && !imm[0];
         EncJ:       ok = (imm == {{11{imm[20]}}, imm[20:0]}) && !imm[0];
         EncU:       ok = (imm[11:0] == 12'h000);
         default:    ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/instruction_encoder.sv
// Packs RV32 instruction fields into a 32-bit word, tags it with a running byte address and
// queues {addr, inst} in a 2-entry FIFO feeding the instruction-memory write stream.
// clk   : clock, rising edge
// reset : asynchronous active-high reset
// bus   : field input stream, address load, output stream and error reporting
module instruction_encoder
   import instruction_encoder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input logic                  clk,
   input logic                  reset,
   instruction_encoder_if.slave bus
);

   logic [63:0] mem_q [2];
   logic [63:0] mem_d [2];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;
   logic        in_ready_q, in_ready_d;
   logic [31:0] addr_q, addr_d;
   logic        err_q, err_d;
   logic [7:0]  err_count_q, err_count_d;

   logic        imm_ok;
   logic        accept, push, pop;
   logic [31:0] inst_addr;
   logic [31:0] inst;
   logic        unused_load_bits;

   assign unused_load_bits = ^bus.load_addr[1:0];

   instruction_encoder_imm_range_check u_imm_check (
      .en  (bus.en),
      .imm (bus.imm),
      .ok  (imm_ok)
   );

   // Field packing; fields a format does not use stay zero.
   always_comb begin
      inst      = '0;
      inst[6:0] = bus.opcode;
      case (bus.en)
         EncR: begin
            inst[31:25] = bus.funct7;
            inst[24:20] = bus.rs2;
            inst[19:15] = bus.rs1;
            inst[14:12] = bus.funct3;
            inst[11:7]  = bus.rd;
         end
         EncI: begin
            inst[31:20] = bus.imm[11:0];
            inst[19:15] = bus.rs1;
            inst[14:12] = bus.funct3;
            inst[11:7]  = bus.rd;
         end
         EncS: begin
            inst[31:25] = bus.imm[11:5];
            inst[24:20] = bus.rs2;
            inst[19:15] = bus.rs1;
            inst[14:12] = bus.funct3;
            inst[11:7]  = bus.imm[4:0];
         end
         EncB: begin
            inst[31:25] = {bus.imm[12], bus.imm[10:5]};
            inst[24:20] = bus.rs2;
            inst[19:15] = bus.rs1;
            inst[14:12] = bus.funct3;
            inst[11:7]  = {bus.imm[4:1], bus.imm[11]};
         end
         EncU: begin
            inst[31:12] = bus.imm[31:12];
            inst[11:7]  = bus.rd;
         end
         EncJ: begin
            inst[31:12] = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12]};
            inst[11:7]  = bus.rd;
         end
         default: inst = '0;
      endcase
   end

   always_comb begin
      accept = bus.in_valid && in_ready_q;
      push   = accept && imm_ok;
      pop    = (count_q != 2'd0) && bus.out_ready;

      // A load in the accept cycle re-targets the instruction being accepted.
      inst_addr = bus.load_en ? {bus.load_addr[31:2], 2'b00} : addr_q;
      addr_d    = push ? inst_addr + 32'd4 : inst_addr;

      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = {inst_addr, inst};
      end
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      // Registered from next occupancy, so a pop while full frees a slot one cycle later.
      in_ready_d = (count_d < 2'd2);

      err_d       = accept && !imm_ok;
      err_count_d = err_count_q;
      if (err_d && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         in_ready_q  <= 1'b1;
         addr_q      <= BASE_ADDR;
         err_q       <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         in_ready_q  <= in_ready_d;
         addr_q      <= addr_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (count_q != 2'd0);
   assign bus.out_addr  = mem_q[rd_ptr_q][63:32];
   assign bus.out_inst  = mem_q[rd_ptr_q][31:0];
   assign bus.err       = err_q;
   assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: encodings, rejects, back-pressure, loads, reset.
module tb_instruction_encoder;
   import instruction_encoder_pkg::*;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;

   instruction_encoder_if bus ();

   instruction_encoder #(
      .BASE_ADDR (32'h0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fields(input EncodingType e, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] imm);
      bus.en     = e;
      bus.opcode = op;
      bus.funct3 = f3;
      bus.funct7 = f7;
      bus.rd     = rd;
      bus.rs1    = rs1;
      bus.rs2    = rs2;
      bus.imm    = imm;
   endtask

   // Present one field set and return #1 after the edge that accepts it.
   task automatic send(input EncodingType e, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
      int n;
      set_fields(e, op, f3, f7, rd, rs1, rs2, imm);
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check_eq("send_timeout", 32'd0, 32'd1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      bus.load_en  = 1'b0;
      reset        = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic [31:0] addr, input logic [31:0] inst);
      check_eq({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check_eq({tag, "_addr"}, bus.out_addr, addr);
      check_eq({tag, "_inst"}, bus.out_inst, inst);
   endtask

   initial begin
      n_checks      = 0;
      n_pass        = 0;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.load_en   = 1'b0;
      bus.load_addr = '0;
      bus.out_ready = 1'b1;
      set_fields(EncR, 7'h0, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
      tick();
      tick();
      reset = 1'b0;

      check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check_eq("rst_err", {31'd0, bus.err}, 32'd0);
      check_eq("rst_err_count", {24'd0, bus.err_count}, 32'd0);
      check_eq("rst_out_addr", bus.out_addr, 32'd0);
      check_eq("rst_out_inst", bus.out_inst, 32'd0);

      // I then S; R-type with funct7 after
      send(EncI, OpOpImm, 3'd0, 7'h7F, 5'd1, 5'd0, 5'd0, 32'd5);
      check_out("i_type", 32'h0, 32'h0050_0093);
      send(EncS, OpStore, 3'd2, 7'h7F, 5'd31, 5'd1, 5'd2, 32'd8);
      check_out("s_type", 32'h4, 32'h0020_A423);
      send(EncR, OpOp, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'hFFFF_FFFF);
      check_out("r_type", 32'h8, 32'h4020_81B3);

      // B, J, U back to back from a fresh reset
      do_reset();
      send(EncB, OpBranch, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
      check_out("b_type", 32'h0, 32'hFE00_0EE3);
      send(EncJ, OpJal, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
      check_out("j_type", 32'h4, 32'h0000_006F);
      send(EncU, OpLui, 3'd0, 7'h0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
      check_out("u_type", 32'h8, 32'h1234_52B7);
      tick();
      check_eq("drain_valid", {31'd0, bus.out_valid}, 32'd0);

      // Rejects: out-of-range I, odd B offset, U with low bits set
      do_reset();
      send(EncI, OpOpImm, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd2048);
      check_eq("rej1_err", {31'd0, bus.err}, 32'd1);
      check_eq("rej1_cnt", {24'd0, bus.err_count}, 32'd1);
      check_eq("rej1_valid", {31'd0, bus.out_valid}, 32'd0);
      tick();
      check_eq("rej1_err_low", {31'd0, bus.err}, 32'd0);
      send(EncB, OpBranch, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'd7);
      check_eq("rej2_err", {31'd0, bus.err}, 32'd1);
      check_eq("rej2_cnt", {24'd0, bus.err_count}, 32'd2);
      check_eq("rej2_valid", {31'd0, bus.out_valid}, 32'd0);
      // Even B offset is in range and takes the first address
      send(EncB, OpBranch, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'd6);
      check_out("b_even", 32'h0, 32'h0000_0363);
      check_eq("b_even_err", {31'd0, bus.err}, 32'd0);
      send(EncU, OpLui, 3'd0, 7'h0, 5'd5, 5'd0, 5'd0, 32'h1234_5001);
      check_eq("rej3_err", {31'd0, bus.err}, 32'd1);
      check_eq("rej3_cnt", {24'd0, bus.err_count}, 32'd3);

      // Back-pressure with three inputs
      do_reset();
      bus.out_ready = 1'b0;
      send(EncI, OpOpImm, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd1);
      check_eq("bp_ready1", {31'd0, bus.in_ready}, 32'd1);
      send(EncI, OpOpImm, 3'd0, 7'h0, 5'd2, 5'd0, 5'd0, 32'd2);
      check_eq("bp_ready2", {31'd0, bus.in_ready}, 32'd0);
      set_fields(EncI, OpOpImm, 3'd0, 7'h0, 5'd3, 5'd0, 5'd0, 32'd3);
      bus.in_valid = 1'b1;
      tick();
      check_out("bp_hold", 32'h0, 32'h0010_0093);
      check_eq("bp_ready_hold", {31'd0, bus.in_ready}, 32'd0);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check_out("bp_pop1", 32'h4, 32'h0020_0113);
      check_eq("bp_ready_pop", {31'd0, bus.in_ready}, 32'd1);
      tick();
      bus.in_valid = 1'b0;
      check_eq("bp_ready_full", {31'd0, bus.in_ready}, 32'd0);
      check_out("bp_head", 32'h4, 32'h0020_0113);
      bus.out_ready = 1'b1;
      tick();
      check_out("bp_third", 32'h8, 32'h0030_0193);
      tick();
      check_eq("bp_empty", {31'd0, bus.out_valid}, 32'd0);

      // Reset with buffered data
      bus.out_ready = 1'b0;
      send(EncI, OpOpImm, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd5);
      reset = 1'b1;
      #1;
      check_eq("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check_eq("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      reset         = 1'b0;
      bus.out_ready = 1'b1;
      send(EncI, OpOpImm, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd5);
      check_out("post_rst", 32'h0, 32'h0050_0093);

      // Load alone, then load coincident with accept and wrap
      bus.load_en   = 1'b1;
      bus.load_addr = 32'h0000_0103;
      tick();
      bus.load_en = 1'b0;
      send(EncI, OpOpImm, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd5);
      check_out("load_only", 32'h100, 32'h0050_0093);
      bus.load_en   = 1'b1;
      bus.load_addr = 32'hFFFF_FFFE;
      send(EncI, OpOpImm, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd5);
      bus.load_en = 1'b0;
      check_out("load_acc", 32'hFFFF_FFFC, 32'h0050_0093);
      send(EncS, OpStore, 3'd2, 7'h0, 5'd0, 5'd1, 5'd2, 32'd8);
      check_out("wrap", 32'h0, 32'h0020_A423);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
